// File: rtl/dual_ram_arbiter.sv
// dual_ram_arbiter: shares one RAM port between the instruction and data
// caches of two CPUs. Data beats instruction within a CPU, and CPUs take
// turns when both ask. A grant is held until the RAM answers ACCESS, or
// until the owning request is withdrawn.
module dual_ram_arbiter #(
   parameter int CPUS   = 2,
   parameter int WORD_W = 32
) (
   input  logic                          CLK,
   input  logic                          nRST,
   input  logic [CPUS-1:0]               iREN,
   input  logic [CPUS-1:0]               dREN,
   input  logic [CPUS-1:0]               dWEN,
   input  logic [CPUS-1:0][WORD_W-1:0]   iaddr,
   input  logic [CPUS-1:0][WORD_W-1:0]   daddr,
   input  logic [CPUS-1:0][WORD_W-1:0]   dstore,
   output logic [CPUS-1:0]               iwait,
   output logic [CPUS-1:0]               dwait,
   output logic [CPUS-1:0][WORD_W-1:0]   iload,
   output logic [CPUS-1:0][WORD_W-1:0]   dload,
   input  logic [1:0]                    ramstate,
   input  logic [WORD_W-1:0]             ramload,
   output logic                          ramREN,
   output logic                          ramWEN,
   output logic [WORD_W-1:0]             ramaddr,
   output logic [WORD_W-1:0]             ramstore
);

   // RAM state encoding is FREE=0, BUSY=1, ACCESS=2, ERROR=3; only ACCESS
   // changes arbiter behaviour, the other three simply keep the grant.
   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t state_q, state_d;
   logic   ownerCpu_q, ownerCpu_d;
   logic   ownerData_q, ownerData_d;
   logic   lastCpu_q, lastCpu_d;

   logic [CPUS-1:0] cpuReq;
   logic [CPUS-1:0] dataReq;
   logic            winner;
   logic            ownerReq;

   assign cpuReq  = iREN | dREN | dWEN;
   assign dataReq = dREN | dWEN;

   // On a tie the CPU that did not complete last wins; otherwise the lone
   // requester wins (cpuReq[1] is 1 exactly when CPU1 is that requester).
   assign winner   = (&cpuReq) ? ~lastCpu_q : cpuReq[1];
   assign ownerReq = ownerData_q ? dataReq[ownerCpu_q] : iREN[ownerCpu_q];

   assign iload = {CPUS{ramload}};
   assign dload = {CPUS{ramload}};

   // Arbiter state register; lastCpu resets to 1 so CPU0 wins the first tie.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         ownerCpu_q  <= 1'b0;
         ownerData_q <= 1'b0;
         lastCpu_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         ownerCpu_q  <= ownerCpu_d;
         ownerData_q <= ownerData_d;
         lastCpu_q   <= lastCpu_d;
      end
   end

   // Next-state logic and RAM/wait drive; the RAM is only driven in GRANT
   // and the owner's address/data follow the inputs live while granted.
   always_comb begin
      state_d     = state_q;
      ownerCpu_d  = ownerCpu_q;
      ownerData_d = ownerData_q;
      lastCpu_d   = lastCpu_q;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      iwait       = '1;
      dwait       = '1;
      case (state_q)
         IDLE: begin
            if (|cpuReq) begin
               ownerCpu_d  = winner;
               ownerData_d = dataReq[winner];
               state_d     = GRANT;
            end
         end
         GRANT: begin
            ramstore = dstore[ownerCpu_q];
            if (ownerData_q) begin
               ramaddr = daddr[ownerCpu_q];
               ramWEN  = dWEN[ownerCpu_q];
               ramREN  = dREN[ownerCpu_q] & ~dWEN[ownerCpu_q];
            end else begin
               ramaddr = iaddr[ownerCpu_q];
               ramREN  = iREN[ownerCpu_q];
            end
            if (ramstate == RAM_ACCESS) begin
               if (ownerData_q) begin
                  dwait[ownerCpu_q] = 1'b0;
               end else begin
                  iwait[ownerCpu_q] = 1'b0;
               end
               lastCpu_d = ownerCpu_q;
               state_d   = IDLE;
            end else if (!ownerReq) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dual_ram_arbiter.sv
// tb_dual_ram_arbiter: scenario tasks plus a randomized run, every cycle
// compared against a transaction-level model of the arbitration rules.
module tb_dual_ram_arbiter;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   logic              CLK;
   logic              nRST;
   logic [1:0]        iREN, dREN, dWEN;
   logic [1:0][31:0]  iaddr, daddr, dstore;
   logic [1:0]        iwait, dwait;
   logic [1:0][31:0]  iload, dload;
   logic [1:0]        ramstate;
   logic [31:0]       ramload;
   logic              ramREN, ramWEN;
   logic [31:0]       ramaddr, ramstore;

   int errors = 0;
   int checks = 0;

   // Model: is a transaction outstanding, who owns it, which side, and who
   // finished last.
   bit mGrant;
   int mOwner;
   bit mData;
   int mLast;

   dual_ram_arbiter #(.CPUS(2), .WORD_W(32)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
      .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramstate(ramstate), .ramload(ramload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [69:0] dutPack();
      return {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore};
   endfunction

   function automatic logic [69:0] modelPack();
      logic [1:0]  ew = 2'b11, dw = 2'b11;
      logic        r = 1'b0, w = 1'b0;
      logic [31:0] a = '0, s = '0;
      if (mGrant) begin
         s = dstore[mOwner];
         if (mData) begin
            a = daddr[mOwner];
            w = dWEN[mOwner];
            r = dREN[mOwner] && !dWEN[mOwner];
         end else begin
            a = iaddr[mOwner];
            r = iREN[mOwner];
         end
         if (ramstate == ACCESS) begin
            if (mData) dw[mOwner] = 1'b0;
            else       ew[mOwner] = 1'b0;
         end
      end
      return {ew, dw, r, w, a, s};
   endfunction

   task automatic modelAdvance();
      bit r0, r1;
      r0 = iREN[0] || dREN[0] || dWEN[0];
      r1 = iREN[1] || dREN[1] || dWEN[1];
      if (!mGrant) begin
         if (r0 || r1) begin
            mOwner = (r0 && r1) ? 1 - mLast : (r0 ? 0 : 1);
            mData  = dREN[mOwner] || dWEN[mOwner];
            mGrant = 1'b1;
         end
      end else if (ramstate == ACCESS) begin
         mLast  = mOwner;
         mGrant = 1'b0;
      end else if (!(mData ? (dREN[mOwner] || dWEN[mOwner]) : iREN[mOwner])) begin
         mGrant = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic [1:0] i, input logic [1:0] d,
                                input logic [1:0] w, input logic [1:0] rs);
      iREN = i; dREN = d; dWEN = w; ramstate = rs;
      ramload = $urandom;
   endtask

   task automatic endCycle();
      modelAdvance();
      @(posedge CLK);
      #1;
   endtask

   task automatic doReset();
      nRST = 1'b0;
      mGrant = 1'b0; mOwner = 0; mData = 1'b0; mLast = 1;
      @(posedge CLK);
      #1;
      applyStimulus(2'b00, 2'b00, 2'b00, FREE);
      nRST = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(2'b11, 2'b11, 2'b11, ACCESS);
      iaddr = {32'h1111_1111, 32'h2222_2222};
      daddr = {32'h3333_3333, 32'h4444_4444};
      dstore = {32'h5555_5555, 32'h6666_6666};
      nRST = 1'b0;
      mGrant = 1'b0; mOwner = 0; mData = 1'b0; mLast = 1;
      @(posedge CLK);
      #2;
      checks++;
      if (dutPack() !== {2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected %h", dutPack(),
                  {2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0});
      end
      applyStimulus(2'b00, 2'b00, 2'b00, FREE);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      #1;
   endtask

   task automatic test_single_read();
      daddr[0] = 32'h100;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(2'b00, (k < 4) ? 2'b01 : 2'b00, 2'b00, (k == 3) ? ACCESS : BUSY);
         #1;
         checks++;
         if (dutPack() !== modelPack()) begin
            errors++;
            $display("[TB] FAIL single_model k=%0d: got %h expected %h", k, dutPack(), modelPack());
         end
         checks++;
         if ({ramREN, ramaddr} !== ((k >= 1 && k <= 3) ? {1'b1, 32'h100} : 33'h0)) begin
            errors++;
            $display("[TB] FAIL single_drive k=%0d: got %b/%h", k, ramREN, ramaddr);
         end
         checks++;
         if (dwait[0] !== ((k == 3) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("[TB] FAIL single_dwait k=%0d: got %b expected %b", k, dwait[0], k != 3);
         end
         checks++;
         if (iload !== {ramload, ramload} || dload !== {ramload, ramload}) begin
            errors++;
            $display("[TB] FAIL load_broadcast k=%0d: got %h/%h expected %h", k, iload, dload, ramload);
         end
         endCycle();
      end
   endtask

   task automatic test_priority();
      dstore[0] = 32'hDEAD_BEEF;
      iaddr[0]  = $urandom;
      for (int k = 0; k < 7; k++) begin
         applyStimulus((k <= 5) ? 2'b01 : 2'b00, 2'b00, (k <= 2) ? 2'b01 : 2'b00,
                       (k == 2 || k == 5) ? ACCESS : BUSY);
         #1;
         checks++;
         if (dutPack() !== modelPack()) begin
            errors++;
            $display("[TB] FAIL priority_model k=%0d: got %h expected %h", k, dutPack(), modelPack());
         end
         if (k == 1) begin
            checks++;
            if ({ramWEN, ramstore, iwait[0]} !== {1'b1, 32'hDEAD_BEEF, 1'b1}) begin
               errors++;
               $display("[TB] FAIL priority_write: got %b/%h/%b expected 1/deadbeef/1",
                        ramWEN, ramstore, iwait[0]);
            end
         end
         if (k == 3) begin
            checks++;
            if ({ramREN, ramWEN} !== 2'b00) begin
               errors++;
               $display("[TB] FAIL priority_gap: got %b expected 00", {ramREN, ramWEN});
            end
         end
         if (k == 4) begin
            checks++;
            if ({ramREN, ramaddr} !== {1'b1, iaddr[0]}) begin
               errors++;
               $display("[TB] FAIL priority_fetch: got %b/%h expected 1/%h", ramREN, ramaddr, iaddr[0]);
            end
         end
         endCycle();
      end
   endtask

   task automatic test_abort();
      iaddr[1] = $urandom;
      daddr[1] = 32'hABCD_0001;
      daddr[0] = 32'hABCD_0000;
      for (int k = 0; k < 6; k++) begin
         if (k <= 1)      applyStimulus(2'b10, 2'b00, 2'b00, BUSY);
         else if (k == 2) applyStimulus(2'b00, 2'b00, 2'b00, BUSY);
         else if (k == 3) applyStimulus(2'b00, 2'b11, 2'b00, BUSY);
         else if (k == 4) applyStimulus(2'b00, 2'b11, 2'b00, ACCESS);
         else             applyStimulus(2'b00, 2'b00, 2'b00, FREE);
         #1;
         checks++;
         if (dutPack() !== modelPack()) begin
            errors++;
            $display("[TB] FAIL abort_model k=%0d: got %h expected %h", k, dutPack(), modelPack());
         end
         if (k <= 3) begin
            checks++;
            if (iwait[1] !== 1'b1 || ramREN !== (k == 1)) begin
               errors++;
               $display("[TB] FAIL abort_drive k=%0d: got iwait1=%b ren=%b expected 1/%b",
                        k, iwait[1], ramREN, k == 1);
            end
         end
         if (k == 4) begin
            checks++;
            if (ramaddr !== daddr[1] || dwait[1] !== 1'b0) begin
               errors++;
               $display("[TB] FAIL abort_last: got %h/%b expected %h/0", ramaddr, dwait[1], daddr[1]);
            end
         end
         endCycle();
      end
   endtask

   task automatic test_error_hold();
      daddr[0] = $urandom;
      for (int k = 0; k < 13; k++) begin
         applyStimulus(2'b00, (k <= 11) ? 2'b01 : 2'b00, 2'b00,
                       (k == 0) ? FREE : ((k == 11) ? ACCESS : ERROR));
         #1;
         checks++;
         if (dutPack() !== modelPack()) begin
            errors++;
            $display("[TB] FAIL error_model k=%0d: got %h expected %h", k, dutPack(), modelPack());
         end
         if (k >= 1 && k <= 11) begin
            checks++;
            if ({ramREN, dwait[0]} !== {1'b1, (k != 11)}) begin
               errors++;
               $display("[TB] FAIL error_hold k=%0d: got ren=%b dwait0=%b expected 1/%b",
                        k, ramREN, dwait[0], k != 11);
            end
         end
         endCycle();
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 2; k++) begin
         applyStimulus(2'b00, 2'b00, 2'b10, BUSY);
         #1;
         checks++;
         if (dutPack() !== modelPack()) begin
            errors++;
            $display("[TB] FAIL resetmid_model k=%0d: got %h expected %h", k, dutPack(), modelPack());
         end
         endCycle();
      end
      #1;
      nRST = 1'b0;
      mGrant = 1'b0; mOwner = 0; mData = 1'b0; mLast = 1;
      #1;
      checks++;
      if (dutPack() !== {2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL resetmid_async: got %h expected all waits high, enables low", dutPack());
      end
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      daddr = {32'hC0DE_0001, 32'hC0DE_0000};
      for (int k = 0; k < 3; k++) begin
         applyStimulus(2'b00, (k <= 1) ? 2'b11 : 2'b00, 2'b00, (k == 1) ? ACCESS : BUSY);
         #1;
         checks++;
         if (dutPack() !== modelPack()) begin
            errors++;
            $display("[TB] FAIL resetmid_tie_model k=%0d: got %h expected %h", k, dutPack(), modelPack());
         end
         if (k == 1) begin
            checks++;
            if (ramaddr !== 32'hC0DE_0000 || dwait !== 2'b10) begin
               errors++;
               $display("[TB] FAIL resetmid_tie: got %h/%b expected c0de0000/10", ramaddr, dwait);
            end
         end
         endCycle();
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      doReset();
      daddr = {32'h0000_0B0B, 32'h0000_0A0A};
      for (int k = 0; k < 12; k++) begin
         applyStimulus(2'b00, 2'b11, 2'b00, (k % 3 == 2) ? ACCESS : BUSY);
         #1;
         checks++;
         if (dutPack() !== modelPack()) begin
            errors++;
            $display("[TB] FAIL rr_model k=%0d: got %h expected %h", k, dutPack(), modelPack());
         end
         if (dwait != 2'b11) order.push_back(dwait[0] ? 1 : 0);
         endCycle();
      end
      applyStimulus(2'b00, 2'b00, 2'b00, FREE);
      checks++;
      if (order.size() != 4) begin
         errors++;
         $display("[TB] FAIL rr_count: got %0d expected 4", order.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (order[j] != j % 2) begin
               errors++;
               $display("[TB] FAIL rr_owner %0d: got cpu%0d expected cpu%0d", j, order[j], j % 2);
            end
         end
      end
      #1;
      endCycle();
   endtask

   task automatic test_random();
      logic [1:0] i, d, w;
      i = 0; d = 0; w = 0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            i = 2'($urandom); d = 2'($urandom); w = 2'($urandom);
         end
         applyStimulus(i, d, w, 2'($urandom));
         iaddr = {32'($urandom), 32'($urandom)};
         daddr = {32'($urandom), 32'($urandom)};
         dstore = {32'($urandom), 32'($urandom)};
         #1;
         checks++;
         if (dutPack() !== modelPack()) begin
            errors++;
            $display("[TB] FAIL random_model k=%0d: got %h expected %h", k, dutPack(), modelPack());
         end
         checks++;
         if (iload !== {ramload, ramload} || dload !== {ramload, ramload}) begin
            errors++;
            $display("[TB] FAIL random_load k=%0d: got %h/%h expected %h", k, iload, dload, ramload);
         end
         endCycle();
      end
   endtask

   initial begin
      nRST = 1'b1;
      applyStimulus(2'b00, 2'b00, 2'b00, FREE);
      iaddr = '0; daddr = '0; dstore = '0;
      mGrant = 1'b0; mOwner = 0; mData = 1'b0; mLast = 1;
      #1;
      test_reset();
      test_single_read();
      test_priority();
      test_abort();
      test_error_hold();
      test_reset_mid();
      test_round_robin();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dual_ram_arbiter.md
# dual_ram_arbiter

Sequential arbiter that shares the single RAM port between the instruction and data caches of two CPUs (CPUS = 2). It sits between the per-CPU cache request lines and the RAM, and grants one requester at a time. Within a CPU, data beats instruction. Across CPUs, grants alternate round-robin. Each granted transaction is held until the RAM reports ACCESS.

## Interface
Parameters:
- CPUS, 2, number of CPUs; fixed at 2 for this block
- WORD_W, 32, data and address width (word_t)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  2  instruction read request, per CPU
- dREN  in  2  data read request, per CPU
- dWEN  in  2  data write request, per CPU
- iaddr  in  2×WORD_W  instruction address, per CPU
- daddr  in  2×WORD_W  data address, per CPU
- dstore  in  2×WORD_W  write data, per CPU
- iwait  out  2  instruction stall, per CPU
- dwait  out  2  data stall, per CPU
- iload  out  2×WORD_W  instruction read data, per CPU
- dload  out  2×WORD_W  data read data, per CPU
- ramstate  in  2  RAM state: FREE, BUSY, ACCESS, ERROR (ramstate_t)
- ramload  in  WORD_W  RAM read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data

## Operation
Registered state:
- state ∈ {IDLE, GRANT}
- owner_cpu (1 bit)
- owner_d (1 = data, 0 = instruction)
- last_cpu (1 bit)

Requests:
- A CPU is "requesting" when iREN | dREN | dWEN is set for that CPU.
- The data request of CPU c is dREN[c] | dWEN[c].

IDLE:
- No RAM enables are driven.
- If any CPU is requesting, pick the winner:
  - If both CPUs request, the winner is the CPU ≠ last_cpu.
  - Otherwise the winner is the single requesting CPU.
- Set owner_d = 1 if the winner's data request is active, else 0.
- Move to GRANT.

GRANT, RAM drive:
- If owner_d = 1: ramaddr = daddr[owner]; ramWEN = dWEN[owner]; ramREN = dREN[owner] & !dWEN[owner]. Write has precedence over read.
- If owner_d = 0: ramaddr = iaddr[owner]; ramREN = iREN[owner]; ramWEN = 0.
- ramstore = dstore[owner_cpu] always.

GRANT, transitions:
- ramstate == ACCESS: deassert the owner's wait (dwait or iwait) for that cycle, set last_cpu ← owner_cpu, and go to IDLE.
- Owner's selected request drops (abort): go to IDLE. No wait pulse is produced and last_cpu is unchanged.
- BUSY, FREE or ERROR: stay in GRANT with all waits held at 1. ERROR never releases the grant.

Other outputs:
- iload[c] = dload[c] = ramload for both CPUs (broadcast).
- Every wait is 1 except the owner's selected wait in an ACCESS cycle of GRANT.
- Outside GRANT: ramREN = ramWEN = 0, and ramaddr = ramstore = 0.

Reset (nRST low, asynchronous):
- state = IDLE, owner_cpu = 0, owner_d = 0, last_cpu = 1, so CPU0 wins the first tie.
- Resulting outputs: all waits = 1, ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0.
- Reset asserted mid-GRANT drops the RAM enables immediately, with no completion.

## Timing
- Arbitration latency: a request present at the edge that ends cycle N (state IDLE) drives the RAM in cycle N+1.
- Completion: when ACCESS arrives in cycle M, the wait is low in cycle M only and state is IDLE in cycle M+1.
- Back-to-back requests: the next grant drives the RAM in M+2, leaving one mandatory idle cycle between transactions.
- A request that arrives during GRANT waits; it is considered at the next IDLE cycle.
- Grant inputs are sampled only in IDLE. The owner's address and data follow the inputs live during GRANT.
- ACCESS seen while in IDLE is ignored.

## Test plan
- Single read: reset, then dREN[0] = 1 with daddr[0] = 0x100 and ramstate BUSY for 2 cycles, then ACCESS. Expect ramREN = 1 and ramaddr = 0x100 from cycle 1, dwait[0] = 0 only in the ACCESS cycle, and IDLE on the next cycle.
- Priority within a CPU: iREN[0] = dWEN[0] = 1 with dstore[0] = 0xDEADBEEF. Expect the data write first (ramWEN = 1, ramstore = 0xDEADBEEF) while iwait[0] stays 1. The instruction fetch is granted only after the idle cycle.
- Round-robin across CPUs: both CPUs hold dREN continuously with ACCESS every third cycle. Expect the owner sequence CPU0, CPU1, CPU0, CPU1, and never two consecutive grants to the same CPU.
- Abort: grant iREN[1], then drop iREN[1] while ramstate = BUSY. Expect IDLE next cycle, iwait[1] never 0, last_cpu unchanged, and ramREN = 0.
- Error hold: grant dREN[0] and hold ramstate = ERROR for 10 cycles. Expect dwait[0] = 1 and ramREN = 1 throughout. ACCESS then completes the transaction normally.
- Reset mid-transaction: assert nRST low during GRANT. Expect ramREN = ramWEN = 0 and all waits = 1 asynchronously. After release, a tie between the CPUs is won by CPU0.
